// File: rtl/vga_p_pkg.sv
// Shared definitions for the queued VGA text-screen command peripheral:
// register map, STATUS bit positions and the sequencer state encoding.
package vga_p_pkg;

    localparam int ADDR_CMD    = 0;
    localparam int ADDR_CHAR   = 1;
    localparam int ADDR_X      = 2;
    localparam int ADDR_Y      = 3;
    localparam int ADDR_STATUS = 4;
    localparam int ADDR_CLR    = 5;

    localparam int STAT_IDLE_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_FULL_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_BUSY_BIT  = 4;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_IDLE
    } seq_state_t;

endpackage

// File: rtl/vga_cmd_queue_p_if.sv
// CPU peripheral bus for the VGA command queue: single-port register access
// with a registered read data path.
interface vga_cmd_queue_p_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;

    modport master (output wea, output addra, output dina, input douta);
    modport slave  (input wea, input addra, input dina, output douta);
endinterface

// File: rtl/vga_cmd_fifo.sv
// Synchronous show-ahead FIFO; a pop and a push in the same cycle are both
// honoured, so a full FIFO can accept a push while it is being drained.
module vga_cmd_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // NOTE: storage carries no reset; the pointers and count alone define
    // which entries are valid, so resetting the array would only cost logic.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_cmd_queue_p.sv
// Memory-mapped VGA text-screen peripheral: shadow registers feed a command
// FIFO that a sequencer drains into the text controller one command at a time.
module vga_cmd_queue_p
    import vga_p_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CMD_W      = 8,
    parameter int CHAR_W     = 7,
    parameter int X_W        = 7,
    parameter int Y_W        = 5,
    parameter int BUSY_TO    = 4
) (
    input  logic                clk,
    input  logic                rst,
    vga_cmd_queue_p_if.slave    bus,
    input  logic                vga_ctrl_idle,
    output logic [CMD_W-1:0]    vga_cmd_word,
    output logic [CHAR_W-1:0]   vga_char_code,
    output logic [X_W-1:0]      vga_cursor_x_pos,
    output logic [Y_W-1:0]      vga_cursor_y_pos,
    output logic                irq_empty
);
    localparam int ENTRY_W = CMD_W + CHAR_W + X_W + Y_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W   = $clog2(BUSY_TO + 1);

    logic [CHAR_W-1:0]  char_q;
    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic               overflow;
    seq_state_t         state;
    logic [TMR_W-1:0]   timer;

    logic               push_req;
    logic               pop;
    logic               ovf_set;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_wr;
    logic [ENTRY_W-1:0] fifo_rd;
    logic [CMD_W-1:0]   rd_cmd;
    logic [CHAR_W-1:0]  rd_char;
    logic [X_W-1:0]     rd_x;
    logic [Y_W-1:0]     rd_y;
    logic [DATA_W-1:0]  rd_val;
    logic               unused_dina_hi;

    assign unused_dina_hi = ^bus.dina[DATA_W-1:CMD_W];

    // A zero command word is a no-op and never occupies a FIFO slot.
    assign push_req = bus.wea && (bus.addra == ADDR_W'(ADDR_CMD))
                      && (bus.dina[CMD_W-1:0] != '0);
    assign pop      = (state == ST_IDLE) && !fifo_empty && vga_ctrl_idle;
    assign ovf_set  = push_req && fifo_full && !pop;
    assign fifo_wr  = {bus.dina[CMD_W-1:0], char_q, x_q, y_q};

    assign {rd_cmd, rd_char, rd_x, rd_y} = fifo_rd;

    vga_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_req),
        .wr_data (fifo_wr),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A CLR write and an overflow event in the same cycle leave overflow set.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            overflow <= 1'b0;
        end else begin
            if (bus.wea) begin
                case (bus.addra)
                    ADDR_W'(ADDR_CHAR): char_q <= bus.dina[CHAR_W-1:0];
                    ADDR_W'(ADDR_X):    x_q    <= bus.dina[X_W-1:0];
                    ADDR_W'(ADDR_Y):    y_q    <= bus.dina[Y_W-1:0];
                    ADDR_W'(ADDR_CLR):  if (bus.dina[0]) overflow <= 1'b0;
                    default: ;
                endcase
            end
            if (ovf_set) overflow <= 1'b1;
        end
    end

    // NOTE: every path assigns rd_val a default first so the read mux cannot
    // hold a value between evaluations and infer a latch.
    always_comb begin
        rd_val = '0;
        case (bus.addra)
            ADDR_W'(ADDR_CHAR): rd_val = DATA_W'(char_q);
            ADDR_W'(ADDR_X):    rd_val = DATA_W'(x_q);
            ADDR_W'(ADDR_Y):    rd_val = DATA_W'(y_q);
            ADDR_W'(ADDR_STATUS): begin
                rd_val[STAT_IDLE_BIT]  = vga_ctrl_idle;
                rd_val[STAT_EMPTY_BIT] = fifo_empty;
                rd_val[STAT_FULL_BIT]  = fifo_full;
                rd_val[STAT_OVF_BIT]   = overflow;
                rd_val[STAT_BUSY_BIT]  = (state != ST_IDLE);
                rd_val[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
            end
            default: rd_val = '0;
        endcase
    end

    // NOTE: non-blocking assignment samples pre-edge register values, so a
    // read colliding with a write to the same register returns the old value.
    always_ff @(posedge clk) begin
        if (rst) bus.douta <= '0;
        else     bus.douta <= rd_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            timer            <= '0;
            vga_cmd_word     <= '0;
            vga_char_code    <= '0;
            vga_cursor_x_pos <= '0;
            vga_cursor_y_pos <= '0;
            irq_empty        <= 1'b0;
        end else begin
            irq_empty <= fifo_empty && (state == ST_IDLE) && vga_ctrl_idle;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        vga_cmd_word     <= rd_cmd;
                        vga_char_code    <= rd_char;
                        vga_cursor_x_pos <= rd_x;
                        vga_cursor_y_pos <= rd_y;
                        state            <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    vga_cmd_word <= '0;
                    timer        <= '0;
                    state        <= ST_WAIT_BUSY;
                end
                // Controllers that finish within a cycle never drop idle;
                // the timer stops us waiting for a busy phase that won't come.
                ST_WAIT_BUSY: begin
                    if (!vga_ctrl_idle)                      state <= ST_WAIT_IDLE;
                    else if (timer == TMR_W'(BUSY_TO - 1))   state <= ST_IDLE;
                    else                                     timer <= timer + 1'b1;
                end
                ST_WAIT_IDLE: begin
                    if (vga_ctrl_idle) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_cmd_queue_p.sv
// Self-checking bench for vga_cmd_queue_p: register-map vectors, a controller
// model and a scoreboard of expected command strobes.
module tb_vga_cmd_queue_p;
    import vga_p_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       vga_ctrl_idle;
    logic [7:0] cmd_word;
    logic [6:0] char_code;
    logic [6:0] x_pos;
    logic [4:0] y_pos;
    logic       irq_empty;

    always #5 clk = ~clk;

    vga_cmd_queue_p_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    vga_cmd_queue_p dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .vga_ctrl_idle    (vga_ctrl_idle),
        .vga_cmd_word     (cmd_word),
        .vga_char_code    (char_code),
        .vga_cursor_x_pos (x_pos),
        .vga_cursor_y_pos (y_pos),
        .irq_empty        (irq_empty)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Controller model: after each strobe idle drops for stall_len cycles,
    // unless never_busy models an instant command; hold_low forces a stall.
    logic hold_low   = 1'b0;
    logic never_busy = 1'b0;
    int   stall_len  = 20;
    int   busy_cnt   = 0;

    always @(posedge clk) begin
        if (cmd_word != 0 && !never_busy) busy_cnt <= stall_len;
        else if (busy_cnt > 0)            busy_cnt <= busy_cnt - 1;
    end
    assign vga_ctrl_idle = !hold_low && (busy_cnt == 0);

    typedef struct packed {
        logic [7:0] cmd;
        logic [6:0] ch;
        logic [6:0] x;
        logic [4:0] y;
    } cmd_t;

    cmd_t sb[$];
    int   strobes         = 0;
    int   cyc             = 0;
    int   last_strobe_cyc = 0;
    int   strobe_gap      = 0;
    logic prev_strobe     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cmd_t e;
        if (cmd_word != 0) begin
            strobes++;
            strobe_gap      = cyc - last_strobe_cyc;
            last_strobe_cyc = cyc;
            check("strobe_while_idle", {31'd0, vga_ctrl_idle}, 32'd1);
            check("strobe_one_cycle", {31'd0, prev_strobe}, 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got cmd 0x%02h want none", cmd_word);
            end else begin
                e = sb.pop_front();
                check("strobe_cmd",  {24'd0, cmd_word},  {24'd0, e.cmd});
                check("strobe_char", {25'd0, char_code}, {25'd0, e.ch});
                check("strobe_x",    {25'd0, x_pos},     {25'd0, e.x});
                check("strobe_y",    {27'd0, y_pos},     {27'd0, e.y});
            end
        end
        prev_strobe = (cmd_word != 0);
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.wea   = 1'b1;
        bus.addra = a;
        bus.dina  = d;
        @(negedge clk);
        bus.wea   = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus.wea   = 1'b0;
        bus.addra = a;
        @(negedge clk);
        d = bus.douta;
    endtask

    task automatic push_cmd(input logic [7:0] c, input logic [6:0] ch,
                            input logic [6:0] x, input logic [4:0] y, input bit accept);
        bus_write(4'd1, {25'd0, ch});
        bus_write(4'd2, {25'd0, x});
        bus_write(4'd3, {27'd0, y});
        if (accept) sb.push_back('{cmd: c, ch: ch, x: x, y: y});
        bus_write(4'd0, {24'd0, c});
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t vec[8];

    initial begin
        logic [31:0] rd;
        int          s0;

        vec[0] = '{addr: 4'd1,  wdata: 32'hFFFF_FFC1, exp: 32'h41};
        vec[1] = '{addr: 4'd2,  wdata: 32'h0000_0083, exp: 32'h03};
        vec[2] = '{addr: 4'd3,  wdata: 32'h0000_00E2, exp: 32'h02};
        vec[3] = '{addr: 4'd0,  wdata: 32'h0000_0100, exp: 32'h0};
        vec[4] = '{addr: 4'd4,  wdata: 32'hFFFF_FFFF, exp: 32'h3};
        vec[5] = '{addr: 4'd5,  wdata: 32'h0000_0001, exp: 32'h0};
        vec[6] = '{addr: 4'd6,  wdata: 32'h0000_0055, exp: 32'h0};
        vec[7] = '{addr: 4'd15, wdata: 32'h0000_00AA, exp: 32'h0};

        rst       = 1'b1;
        bus.wea   = 1'b0;
        bus.addra = 4'd4;
        bus.dina  = '0;
        idle_cycles(3);
        check("douta_in_reset", bus.douta, 32'h0);
        check("cmd_word_in_reset", {24'd0, cmd_word}, 32'h0);
        check("irq_in_reset", {31'd0, irq_empty}, 32'h0);
        rst = 1'b0;

        bus_read(4'd4, rd);
        check("status_after_reset", rd, 32'h0000_0003);
        @(negedge clk);
        check("irq_after_reset", {31'd0, irq_empty}, 32'h1);

        // Register map: write each address then read it back.
        for (int i = 0; i < 8; i++) begin
            bus_write(vec[i].addr, vec[i].wdata);
            bus_read(vec[i].addr, rd);
            check($sformatf("regvec_%0d", i), rd, vec[i].exp);
        end

        // Read colliding with a write returns the pre-write value.
        bus.wea = 1'b1; bus.addra = 4'd2; bus.dina = 32'd5;
        @(negedge clk);
        bus.wea = 1'b0;
        check("read_during_write_old", bus.douta, 32'h3);
        bus_read(4'd2, rd);
        check("read_after_write_new", rd, 32'h5);
        bus_write(4'd2, 32'd3);

        // Single command using the shadows left by the vectors.
        s0 = strobes;
        sb.push_back('{cmd: 8'h01, ch: 7'h41, x: 7'd3, y: 5'd2});
        bus_write(4'd0, 32'h01);
        wait_drain("single_drain", 50);
        idle_cycles(30);
        bus_read(4'd4, rd);
        check("single_status_idle", rd, 32'h0000_0003);
        check("single_strobes", strobes - s0, 1);

        // Three commands against a slow controller.
        s0 = strobes;
        for (int i = 0; i < 3; i++)
            push_cmd(8'h20 + 8'(i), 7'h30 + 7'(i), 7'(10 + i), 5'(i + 1), 1'b1);
        wait_drain("three_drain", 200);
        idle_cycles(30);
        check("three_strobes", strobes - s0, 3);

        // Overflow with a stalled controller, then CLR, then full push+pop.
        hold_low = 1'b1;
        for (int i = 0; i < 9; i++)
            push_cmd(8'h40 + 8'(i), 7'(i), 7'(100 - i), 5'(i), i < 8);
        bus_read(4'd4, rd);
        check("full_status", rd, 32'h0000_080C);
        check("irq_while_queued", {31'd0, irq_empty}, 32'h0);
        bus_write(4'd5, 32'h1);
        bus_read(4'd4, rd);
        check("clr_status", rd, 32'h0000_0804);
        bus_write(4'd1, 32'h5A);
        bus_write(4'd2, 32'h11);
        bus_write(4'd3, 32'h1F);
        sb.push_back('{cmd: 8'h77, ch: 7'h5A, x: 7'h11, y: 5'h1F});
        bus.wea = 1'b1; bus.addra = 4'd0; bus.dina = 32'h77;
        hold_low = 1'b0;
        @(negedge clk);
        bus.wea = 1'b0;
        bus_read(4'd4, rd);
        check("full_push_pop_status", rd, 32'h0000_0815);
        wait_drain("overflow_drain", 600);
        idle_cycles(30);

        // Controller that never drops idle: ISSUE, 4 WAIT_BUSY cycles, IDLE, ISSUE.
        never_busy = 1'b1;
        hold_low   = 1'b1;
        push_cmd(8'h61, 7'h01, 7'h02, 5'h03, 1'b1);
        push_cmd(8'h62, 7'h04, 7'h05, 5'h06, 1'b1);
        hold_low = 1'b0;
        wait_drain("timeout_drain", 60);
        check("timeout_strobe_gap", strobe_gap, 6);
        idle_cycles(10);
        never_busy = 1'b0;

        // Reset with four commands queued while the sequencer waits for idle.
        hold_low = 1'b1;
        for (int i = 0; i < 5; i++)
            push_cmd(8'h80 + 8'(i), 7'h50 + 7'(i), 7'(i), 5'(i), 1'b1);
        s0 = strobes;
        hold_low = 1'b0;
        begin
            int n = 0;
            while (strobes == s0 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("rst_first_strobe", strobes - s0, 1);
        idle_cycles(3);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("rst_cmd_word", {24'd0, cmd_word}, 32'h0);
        check("rst_char_code", {25'd0, char_code}, 32'h0);
        check("rst_x_pos", {25'd0, x_pos}, 32'h0);
        rst = 1'b0;
        idle_cycles(40);
        bus_read(4'd4, rd);
        check("rst_status_empty", rd, 32'h0000_0003);
        bus_read(4'd1, rd);
        check("rst_char_shadow", rd, 32'h0);
        idle_cycles(20);
        check("rst_no_more_strobes", strobes - s0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1);
    end

endmodule
